// File: rtl/term_list_extractor.sv
// Serial term-list extractor: scans a latched truth table and emits, in ascending
// order, the indices of the rows matching the selected polarity over valid/ready.
module term_list_extractor #(
    parameter int N_VARS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [(1<<N_VARS)-1:0] truth,
    input  logic                  sel_max,
    output logic                  term_valid,
    input  logic                  term_ready,
    output logic [N_VARS-1:0]     term_idx,
    output logic [7:0]            term_char,
    output logic                  busy,
    output logic                  done,
    output logic [N_VARS:0]       count
);

    localparam int W = 1 << N_VARS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_EMIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state;
    logic [W-1:0]      truth_q;
    logic              sel_q;
    logic [N_VARS-1:0] index;
    logic [7:0]        idx_wide;

    // Table and polarity are captured at start so input changes mid-run cannot
    // corrupt the list; index == all-ones marks the last row and ends the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            truth_q    <= '0;
            sel_q      <= 1'b0;
            index      <= '0;
            term_valid <= 1'b0;
            term_idx   <= '0;
            count      <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        truth_q <= truth;
                        sel_q   <= sel_max;
                        index   <= '0;
                        count   <= '0;
                        state   <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (truth_q[index] == ~sel_q) begin
                        term_idx   <= index;
                        term_valid <= 1'b1;
                        state      <= S_EMIT;
                    end else if (index == '1) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        index <= index + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (term_ready) begin
                        count      <= count + 1'b1;
                        term_valid <= 1'b0;
                        if (index == '1) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            index <= index + 1'b1;
                            state <= S_SCAN;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_SCAN) || (state == S_EMIT);

    // ASCII hex digit: '0'..'9' below ten, 'A'..'F' above ('A' - 10 = 8'h37).
    assign idx_wide  = {{(8-N_VARS){1'b0}}, term_idx};
    assign term_char = (idx_wide < 8'd10) ? (8'h30 + idx_wide) : (8'h37 + idx_wide);

endmodule

// File: tb/tb_term_list_extractor.sv
// Self-checking bench for term_list_extractor: each run's term list is predicted
// from the truth table directly and compared with what the handshake delivers.
module tb_term_list_extractor;

    localparam int N_VARS = 4;
    localparam int W      = 1 << N_VARS;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      truth = '0;
    logic              sel_max = 1'b0;
    logic              term_ready = 1'b0;
    logic              term_valid;
    logic [N_VARS-1:0] term_idx;
    logic [7:0]        term_char;
    logic              busy;
    logic              done;
    logic [N_VARS:0]   count;

    int n_checks = 0;
    int n_errors = 0;

    term_list_extractor #(.N_VARS(N_VARS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .truth      (truth),
        .sel_max    (sel_max),
        .term_valid (term_valid),
        .term_ready (term_ready),
        .term_idx   (term_idx),
        .term_char  (term_char),
        .busy       (busy),
        .done       (done),
        .count      (count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] hex_char(input int v);
        if (v < 10) return 8'(8'h30 + v);
        return 8'(8'h41 + v - 10);
    endfunction

    // stall < 0 picks a random 0..3 cycle hold per term; done_at > 0 checks the
    // start-to-done distance in clock edges, counting the start edge as the first.
    task automatic applyStimulus(input logic [W-1:0] tt, input logic sm, input int stall,
                                 input bit perturb, input int done_at);
        int exp_q[$];
        int pos = 0;
        int edges;
        int stall_left;
        bit held_valid = 1'b0;
        logic [N_VARS-1:0] held_idx = '0;
        bit done_seen = 1'b0;

        for (int i = 0; i < W; i++)
            if (tt[i] != sm) exp_q.push_back(i);
        stall_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;

        truth   = tt;
        sel_max = sm;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        edges = 1;
        while (edges < 400 && !done_seen) begin
            if (perturb) begin
                truth   = W'($urandom);
                sel_max = 1'($urandom);
                start   = 1'($urandom);
            end
            if (done) begin
                done_seen = 1'b1;
                checkOutput("busy_in_done", 32'(busy), 0);
                checkOutput("count", 32'(count), exp_q.size());
                checkOutput("terms_received", pos, exp_q.size());
                if (done_at > 0) checkOutput("done_latency", edges, done_at);
                term_ready = 1'b0;
                start      = perturb;
            end else if (term_valid) begin
                if (held_valid) checkOutput("idx_stable", 32'(term_idx), 32'(held_idx));
                held_idx   = term_idx;
                held_valid = 1'b1;
                if (stall_left > 0) begin
                    term_ready = 1'b0;
                    stall_left--;
                end else begin
                    term_ready = 1'b1;
                    if (pos < exp_q.size()) begin
                        checkOutput("term_idx", 32'(term_idx), exp_q[pos]);
                        checkOutput("term_char", 32'(term_char), 32'(hex_char(exp_q[pos])));
                    end else begin
                        checkOutput("extra_term", 32'(term_idx), 32'hFF);
                    end
                    pos++;
                    held_valid = 1'b0;
                    stall_left = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
                end
            end else begin
                term_ready = 1'($urandom);
            end
            @(posedge clk); #1;
            edges++;
        end
        if (!done_seen) begin
            checkOutput("done_timeout", 0, 1);
        end else begin
            checkOutput("done_pulse_width", 32'(done), 0);
            checkOutput("idle_after_done", 32'(busy), 0);
        end
        start      = 1'b0;
        term_ready = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(term_valid), 0);
        checkOutput("rst_idx", 32'(term_idx), 0);
        checkOutput("rst_char", 32'(term_char), 32'h30);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_count", 32'(count), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] maxterms and minterms of 16'h5363");
        applyStimulus(16'h5363, 1'b1, 0, 1'b0, 0);
        applyStimulus(16'h5363, 1'b0, 0, 1'b0, 0);

        $display("[TB] empty list and full list with back-pressure");
        applyStimulus(16'hFFFF, 1'b1, 0, 1'b0, W + 1);
        applyStimulus(16'hFFFF, 1'b0, 3, 1'b0, 0);

        $display("[TB] reset while emitting the third term");
        truth   = 16'hFFFF;
        sel_max = 1'b0;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 100 && !(term_valid && count == 2); c++) begin
            term_ready = term_valid;
            @(posedge clk); #1;
        end
        term_ready = 1'b0;
        checkOutput("third_term_reached", 32'(term_valid && count == 2), 1);
        checkOutput("third_term_idx", 32'(term_idx), 2);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_valid", 32'(term_valid), 0);
        checkOutput("abort_idx", 32'(term_idx), 0);
        checkOutput("abort_char", 32'(term_char), 32'h30);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_count", 32'(count), 0);
        @(posedge clk); #1;
        checkOutput("abort_no_done", 32'(done), 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(16'h0081, 1'b0, 0, 1'b0, 0);

        $display("[TB] inputs and start toggled during a run");
        applyStimulus(16'hA5C3, 1'b1, -1, 1'b1, 0);

        $display("[TB] random tables");
        for (int r = 0; r < 12; r++)
            applyStimulus(W'($urandom), 1'($urandom), -1, ($urandom_range(0, 1) == 1), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
